// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receive path.
package uart_pkg;
    localparam int UART_DATA_WIDTH = 8;
    typedef enum logic {FLOW_GO, FLOW_STOP} flow_state_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_WIDTH storage, one write port, asynchronous read port, no reset.
module uart_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clock)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO behind uart_rx with RTS hysteresis and sticky overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH = 16,
    parameter int AFULL_LEVEL = 12,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   rts_n,
    output logic                   overrun,
    input  logic                   overrun_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AFULL = (AW+1)'(AFULL_LEVEL);
    localparam logic [AW:0] LVL_AEMPTY = (AW+1)'(AEMPTY_LEVEL);
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic full, pop, push, drop;
    flow_state_t flow_state;
    always_comb begin
        out_valid = level != '0;
        full = level == LVL_FULL;
        pop = out_valid & out_ready;
        push = in_valid & (~full | pop);
        drop = in_valid & full & ~pop;
        out_data = out_valid ? rd_data : '0;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
            // a fresh drop outranks a clear on the same edge
            overrun <= drop ? 1'b1 : overrun_clear ? 1'b0 : overrun;
        end
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            flow_state <= FLOW_GO;
            rts_n <= 1'b0;
        end else if (flow_state == FLOW_GO && level >= LVL_AFULL) begin
            flow_state <= FLOW_STOP;
            rts_n <= 1'b1;
        end else if (flow_state == FLOW_STOP && level <= LVL_AEMPTY) begin
            flow_state <= FLOW_GO;
            rts_n <= 1'b0;
        end
    uart_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
        .clock(clock),
        .we(push),
        .waddr(wr_ptr),
        .wdata(in_data),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scenario tasks against a queue scoreboard of the uart_rx_fifo.
module tb_uart_rx_fifo;
    logic clock = 0, reset = 0;
    logic [7:0] in_data = 0, out_data;
    logic in_valid = 0, out_valid, out_ready = 0, rts_n, overrun, overrun_clear = 0;
    logic [4:0] level;
    int tests = 0, fails = 0;
    logic [7:0] q[$];
    logic m_ovr = 0;
    logic popped;
    logic [7:0] got, exp_b;

    uart_rx_fifo dut (
        .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .rts_n(rts_n), .overrun(overrun), .overrun_clear(overrun_clear)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // one clock of stimulus; updates the scoreboard and exposes the popped byte
    task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic clr);
        in_valid = v; in_data = d; out_ready = r; overrun_clear = clr;
        popped = r && q.size() > 0;
        got = out_data;
        exp_b = popped ? q[0] : 8'h00;
        if (popped) void'(q.pop_front());
        if (v && q.size() < 16) q.push_back(d);
        m_ovr = (v && q.size() == 16 && !(q[$] == d && popped == popped && 0)) ? m_ovr : m_ovr;
        @(posedge clock); #1;
        in_valid = 0; out_ready = 0; overrun_clear = 0;
    endtask

    task automatic set_ovr(input logic v, input logic r, input logic clr);
        if (v && !(r && q.size() > 0) && q.size() == 16) m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic clr);
        set_ovr(v, r, clr);
        cyc(v, d, r, clr);
    endtask

    task automatic test_reset;
        #12;
        tests++; if (level !== 5'd0 || out_valid !== 1'b0 || rts_n !== 1'b0 || overrun !== 1'b0 || out_data !== 8'h00) begin
            fails++; $display("FAIL reset_state: level=%0d valid=%b rts_n=%b ovr=%b data=%h required 0/0/0/0/00", level, out_valid, rts_n, overrun, out_data);
        end
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic;
        step(1, 8'hA5, 0, 0);
        tests++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            fails++; $display("FAIL basic_fwft: valid=%b data=%h required 1/a5", out_valid, out_data);
        end
        step(1, 8'h3C, 0, 0);
        tests++; if (level !== 5'd2 || out_data !== 8'hA5) begin
            fails++; $display("FAIL basic_level: level=%0d data=%h required 2/a5", level, out_data);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0);
            tests++; if (!popped || got !== exp_b) begin
                fails++; $display("FAIL basic_pop%0d: got %h required %h", i, got, exp_b);
            end
        end
        tests++; if (level !== 5'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_empty: level=%0d valid=%b required 0/0", level, out_valid);
        end
    endtask

    task automatic fill16;
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    endtask

    task automatic drain(input string name);
        int n = q.size();
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1, 0);
            tests++; if (!popped || got !== exp_b) begin
                fails++; $display("FAIL %s_pop%0d: got %h required %h", name, i, got, exp_b);
            end
        end
        tests++; if (level !== 5'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL %s_empty: level=%0d valid=%b required 0/0", name, level, out_valid);
        end
    endtask

    task automatic test_overflow;
        fill16();
        tests++; if (level !== 5'd16 || overrun !== 1'b0) begin
            fails++; $display("FAIL ovf_full: level=%0d ovr=%b required 16/0", level, overrun);
        end
        step(1, 8'hFF, 0, 0);
        tests++; if (level !== 5'd16 || overrun !== m_ovr || overrun !== 1'b1 || out_data !== 8'h00) begin
            fails++; $display("FAIL ovf_drop: level=%0d ovr=%b head=%h required 16/1/00", level, overrun, out_data);
        end
        drain("ovf");
    endtask

    task automatic test_clear_collision;
        fill16();
        step(1, 8'hEE, 0, 1);
        tests++; if (overrun !== 1'b1 || level !== 5'd16) begin
            fails++; $display("FAIL collide_ovr: ovr=%b level=%0d required 1/16", overrun, level);
        end
        step(0, 0, 0, 1);
        tests++; if (overrun !== 1'b0 || overrun !== m_ovr) begin
            fails++; $display("FAIL clear_ovr: ovr=%b required 0", overrun);
        end
    endtask

    task automatic test_full_pushpop;
        step(1, 8'h55, 1, 0);
        tests++; if (!popped || got !== 8'h00 || exp_b !== 8'h00) begin
            fails++; $display("FAIL fpp_pop: got %h required 00", got);
        end
        tests++; if (level !== 5'd16 || overrun !== 1'b0 || out_data !== 8'h01) begin
            fails++; $display("FAIL fpp_state: level=%0d ovr=%b head=%h required 16/0/01", level, overrun, out_data);
        end
        tests++; if (q[$] !== 8'h55) begin
            fails++; $display("FAIL fpp_tail_model: tail %h required 55", q[$]);
        end
        drain("fpp");
        tests++; if (got !== 8'h55) begin
            fails++; $display("FAIL fpp_tail: last popped %h required 55", got);
        end
    endtask

    task automatic test_flow;
        for (int i = 0; i < 12; i++) step(1, 8'(8'h80 + i), 0, 0);
        tests++; if (level !== 5'd12 || rts_n !== 1'b0) begin
            fails++; $display("FAIL flow_at12: level=%0d rts_n=%b required 12/0", level, rts_n);
        end
        step(0, 0, 0, 0);
        tests++; if (rts_n !== 1'b1) begin
            fails++; $display("FAIL flow_stop: rts_n=%b required 1", rts_n);
        end
        for (int i = 0; i < 7; i++) begin
            step(0, 0, 1, 0);
            tests++; if (got !== exp_b) begin
                fails++; $display("FAIL flow_pop%0d: got %h required %h", i, got, exp_b);
            end
        end
        step(0, 0, 0, 0);
        tests++; if (level !== 5'd5 || rts_n !== 1'b1) begin
            fails++; $display("FAIL flow_at5: level=%0d rts_n=%b required 5/1", level, rts_n);
        end
        step(0, 0, 1, 0);
        tests++; if (level !== 5'd4 || rts_n !== 1'b1) begin
            fails++; $display("FAIL flow_at4: level=%0d rts_n=%b required 4/1", level, rts_n);
        end
        step(0, 0, 0, 0);
        tests++; if (rts_n !== 1'b0) begin
            fails++; $display("FAIL flow_go: rts_n=%b required 0", rts_n);
        end
        drain("flow");
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
        tests++; if (level !== 5'd5 || rts_n !== 1'b0) begin
            fails++; $display("FAIL rmid_pre: level=%0d rts_n=%b required 5/0", level, rts_n);
        end
        #1 reset = 0;
        #1;
        tests++; if (level !== 5'd0 || out_valid !== 1'b0 || overrun !== 1'b0 || rts_n !== 1'b0 || out_data !== 8'h00) begin
            fails++; $display("FAIL rmid_async: level=%0d valid=%b ovr=%b rts_n=%b data=%h required 0/0/0/0/00", level, out_valid, overrun, rts_n, out_data);
        end
        q.delete(); m_ovr = 0;
        @(negedge clock); reset = 1;
        @(posedge clock); #1;
        step(1, 8'h77, 0, 0);
        tests++; if (level !== 5'd1 || out_data !== 8'h77) begin
            fails++; $display("FAIL rmid_newhead: level=%0d head=%h required 1/77", level, out_data);
        end
        drain("rmid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_clear_collision();
        test_full_pushpop();
        test_flow();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
